// File: rtl/alu_seq_unit.sv
// alu_seq_unit: registered, ready/valid ALU for the multi-cycle RV64 core.
// Decodes alu_op/funct3/funct7 internally. Single-cycle ops have a latency of 1.
// An optional iterative shift-add multiplier (MUL, low half) has a latency of WIDTH+1.
//
// Build option: define ALU_MUL_EN to include the multiplier. Without it, the MUL
// encoding is reported as illegal with a latency of 1.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operation handshake (a, b, alu_op, funct3, funct7)
//   out_valid/out_ready result handshake (result, carry_out, zf, illegal)
//   carry_out           ADD carry, SUB no-borrow, otherwise 0
//   zf                  registered result is zero
//   illegal             decoded operation unsupported; result forced to 0
module alu_seq_unit #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       alu_op,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zf,
    output logic             illegal
);
    localparam int unsigned ShW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;
    typedef enum logic [3:0] {
        OpAdd, OpSub, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpSra, OpOr, OpAnd, OpMul, OpIll
    } op_e;

    state_e           state_q, state_d;
    op_e              op;
    logic             accept;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zf_q, zf_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH:0]   add_full, sub_full;
    logic [ShW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cy;

    // Operation decode
    always_comb begin
        op = OpIll;
        if (alu_op == 2'b00) begin
            op = OpAdd;
        end else if (alu_op == 2'b01) begin
            op = OpSub;
        end else if (alu_op == 2'b10 && funct7 == 7'b0000001) begin
            if (funct3 == 3'b000) begin
`ifdef ALU_MUL_EN
                op = OpMul;
`else
                op = OpIll;
`endif
            end
        end else if (alu_op == 2'b10 && funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
            op = OpIll;
        end else begin
            unique case (funct3)
                3'b000: op = (alu_op == 2'b10 && funct7[5]) ? OpSub : OpAdd;
                3'b001: op = OpSll;
                3'b010: op = OpSlt;
                3'b011: op = OpSltu;
                3'b100: op = OpXor;
                3'b101: op = funct7[5] ? OpSra : OpSrl;
                3'b110: op = OpOr;
                3'b111: op = OpAnd;
            endcase
        end
    end

    // Single-cycle datapath
    assign add_full = {1'b0, a} + {1'b0, b};
    // a + ~b + 1: the carry out is the unsigned no-borrow flag (a >= b)
    assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign shamt    = b[ShW-1:0];

    always_comb begin
        alu_res = '0;
        alu_cy  = 1'b0;
        unique case (op)
            OpAdd: begin
                alu_res = add_full[WIDTH-1:0];
                alu_cy  = add_full[WIDTH];
            end
            OpSub: begin
                alu_res = sub_full[WIDTH-1:0];
                alu_cy  = sub_full[WIDTH];
            end
            OpSll:  alu_res = a << shamt;
            OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OpSltu: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OpXor:  alu_res = a ^ b;
            OpSrl:  alu_res = a >> shamt;
            OpSra:  alu_res = $signed(a) >>> shamt;
            OpOr:   alu_res = a | b;
            OpAnd:  alu_res = a & b;
            default: begin
                alu_res = '0;
                alu_cy  = 1'b0;
            end
        endcase
    end

    assign in_ready  = (state_q == StIdle) || (state_q == StDone && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign carry_out = carry_q;
    assign zf        = zf_q;
    assign illegal   = illegal_q;

`ifdef ALU_MUL_EN
    // Iterative shift-add multiplier, one multiplier bit per cycle
    logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_step;
    logic [ShW-1:0]   cnt_q;
    logic             mul_last;

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_last = (cnt_q == ShW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (accept && op == OpMul) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (state_q == StMul) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_step;
            cnt_q    <= cnt_q + 1'b1;
        end
    end
`endif

    // Next state and result register update
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        carry_d   = carry_q;
        zf_d      = zf_q;
        illegal_d = illegal_q;
        unique case (state_q)
            StIdle: state_d = StIdle;
            StMul: begin
`ifdef ALU_MUL_EN
                if (mul_last) begin
                    result_d  = acc_step;
                    carry_d   = 1'b0;
                    zf_d      = (acc_step == '0);
                    illegal_d = 1'b0;
                    state_d   = StDone;
                end
`else
                state_d = StIdle;
`endif
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            if (op == OpMul) begin
                state_d = StMul;
            end else begin
                result_d  = alu_res;
                carry_d   = alu_cy;
                zf_d      = (alu_res == '0);
                illegal_d = (op == OpIll);
                state_d   = StDone;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            result_q  <= '0;
            carry_q   <= 1'b0;
            zf_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            zf_q      <= zf_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Parametrised, handshaked successor to the combinational ALU + ALU-control pair of the RV64 datapath.
- Decodes alu_op/funct3/funct7 internally, registers every result, and adds an iterative multi-cycle multiplier (RV M-extension MUL, low half).
- Sits between operand fetch and writeback in the multi-cycle core.
- Ready/valid on both sides lets writeback stall it.

Parameters:
- WIDTH, 64, operand/result width; power of two, >= 8. Shift amount = low log2(WIDTH) bits of b.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation offered
- in_ready  output  1  unit can accept operation
- a  input  WIDTH  operand 1
- b  input  WIDTH  operand 2
- alu_op  input  2  00 ADD, 01 SUB, 10 R-type decode, 11 I-type decode
- funct3  input  3  RISC-V funct3
- funct7  input  7  RISC-V funct7
- out_valid  output  1  result held valid
- out_ready  input  1  consumer takes result
- result  output  WIDTH  registered result
- carry_out  output  1  ADD: carry out of bit WIDTH-1; SUB: no-borrow (a >= b unsigned); else 0
- zf  output  1  result == 0
- illegal  output  1  decoded operation unsupported; result forced 0

Behaviour:
- Reset is asynchronous, active-low (rst_n); asserting it anywhere, including mid-multiply, aborts the operation. State -> IDLE; result = 0, carry_out = 0, zf = 0, illegal = 0, out_valid = 0, mul counter = 0.
- Decode for alu_op 10/11, by funct3:
  - 000: ADD, or SUB when alu_op=10 and funct7[5]=1
  - 001: SLL
  - 010: SLT (signed)
  - 011: SLTU
  - 100: XOR
  - 101: SRL, or SRA when funct7[5]=1
  - 110: OR
  - 111: AND
- For alu_op=11, funct7[5] only matters for funct3=101.
- alu_op=10, funct7=0000001, funct3=000: MUL (low WIDTH bits of a*b).
- alu_op=10, funct7=0000001, funct3 != 000: illegal.
- Any other funct7 besides 0000000/0100000 with alu_op=10: illegal.
- SLT/SLTU result is 0 or 1, zero-extended.
- States: IDLE, MUL, DONE.
  - IDLE: in_ready=1. On in_valid, single-cycle and illegal ops compute and register the result, then go to DONE (latency 1, out_valid next cycle). MUL captures a, b, clears the accumulator, counter=0, and goes to MUL.
  - MUL: one shift-add step per cycle (add multiplicand if multiplier LSB set; multiplicand <<1; multiplier >>1). After WIDTH steps, write result and go to DONE. Latency WIDTH+1 from accept to out_valid. in_ready=0.
  - DONE: out_valid=1; result/flags stable until out_ready.
    - On out_ready: in_ready=1 in the same cycle. A simultaneous in_valid is accepted (back-to-back, throughput 1/cycle for single-cycle ops). Otherwise go to IDLE.
    - Without out_ready: in_ready=0, inputs ignored.
- MUL flags: carry_out=0; zf from the low-half result.
- Operands are sampled only at acceptance; later changes to a/b do not affect an in-flight op.
- out_valid never deasserts without out_ready or reset.

Optional Feature:
- ALU_MUL_EN defined: MUL state, counter and shift-add datapath present as above.
- ALU_MUL_EN undefined: no multiplier logic. The MUL encoding decodes as illegal: 1-cycle latency, result 0, zf=1, carry_out=0, illegal=1. MUL state unreachable.

Test Plan (WIDTH=64, out_ready=1 unless noted):
- a=32, b=1, alu_op=00 -> one cycle later out_valid=1, result=0x21, carry_out=0, zf=0.
- a=33, b=33, alu_op=01 -> result=0, zf=1, carry_out=1; then a=0xFFFF_FFFF_FFFF_FFFF, b=6, alu_op=10, funct3=000, funct7=0 -> result=0x5, carry_out=1.
- a=0xFFFF_FFFF_FFFF_FFFF, b=6, alu_op=10, funct3=101:
  - funct7=0 -> result=0x03FF_FFFF_FFFF_FFFF
  - funct7=0100000 -> result=0xFFFF_FFFF_FFFF_FFFF
  - funct3=010 (SLT) -> result=1
  - funct3=011 (SLTU) -> result=0
- MUL a=7, b=6 -> in_ready=0 for 64 cycles, out_valid 65 cycles after accept, result=42. With ALU_MUL_EN undefined: illegal=1, result=0 after 1 cycle.
- Backpressure: out_ready=0 for 5 cycles after ADD result -> result/out_valid stable, new in_valid ignored. out_ready=1 with in_valid=1 the same cycle -> new op accepted, next result appears the following cycle.
- Start MUL a=3, b=5; pull rst_n low at cycle 20 -> outputs 0 immediately, state IDLE. After release, ADD 1+1 -> result=2 with latency 1.
